mul_job_sequencer: RTL and testbench

Command-driven controller that sequences the shared ROM → two-entry register file → 4×4 multiplier → 8-entry RAM datapath. It accepts multiply jobs (two ROM addresses plus a RAM destination) through a 4-deep command FIFO. For each job it drives the ROM address and the RF, multiplier and RAM control lines cycle by cycle, then reads the stored product back and returns it on a response handshake. It replaces free-running control of the datapath with a job-at-a-time, back-pressured sequencer.

---
 rtl/mul_job_sequencer.sv | 158 +++++++++++++++
 tb/tb_mul_job_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_job_sequencer.sv
// Job sequencer: queues {adr1, adr2, adr_ram} jobs and steps ROM -> RF -> multiplier -> RAM -> readback.
// Latency: accepted command yields rsp_valid 7 cycles later when idle; one response per 6 cycles back-to-back.
// Backpressure: cmd_ready = !full; the FSM parks in RESP with all datapath control low until rsp_ready.
module mul_job_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_adr1,
    input  logic [ADDR_W-1:0] cmd_adr2,
    input  logic [ADDR_W-1:0] cmd_adr_ram,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rf_w,
    output logic              rf_da,
    output logic              rf_sa,
    output logic              rf_sb,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              busy,
    output logic [7:0]        jobs_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = 3 * ADDR_W;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD_A  = 3'd1;
    localparam logic [2:0] LOAD_B  = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] READ    = 3'd4;
    localparam logic [2:0] CAPTURE = 3'd5;
    localparam logic [2:0] RESP    = 3'd6;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] job_adr1;
    logic [ADDR_W-1:0] job_adr2;
    logic [ADDR_W-1:0] job_adr_ram;

    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    // A job is pulled either from IDLE or straight out of a completed RESP handshake.
    assign pop       = !empty && ((state == IDLE) || ((state == RESP) && rsp_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_adr1, cmd_adr2, cmd_adr_ram};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = WRITE;
            WRITE:   state_nxt = READ;
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = empty ? IDLE : LOAD_A;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            job_adr1    <= '0;
            job_adr2    <= '0;
            job_adr_ram <= '0;
            rsp_data    <= '0;
            rsp_addr    <= '0;
            jobs_done   <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                {job_adr1, job_adr2, job_adr_ram} <= fifo_mem[rd_ptr];
            end
            if (state == CAPTURE) begin
                rsp_data <= ram_rdata;
                rsp_addr <= job_adr_ram;
            end
            if ((state == RESP) && rsp_ready) begin
                jobs_done <= jobs_done + 8'd1;
            end
        end
    end

    // Moore decode: every datapath control depends only on state and the job register.
    always_comb begin
        rom_addr = '0;
        rf_w     = 1'b0;
        rf_da    = 1'b0;
        rf_sa    = 1'b0;
        rf_sb    = 1'b0;
        ram_we   = 1'b0;
        ram_addr = (state == IDLE) ? '0 : job_adr_ram;
        case (state)
            LOAD_A: begin
                rom_addr = job_adr1;
                rf_w     = 1'b1;
            end
            LOAD_B: begin
                rom_addr = job_adr2;
                rf_w     = 1'b1;
                rf_da    = 1'b1;
            end
            WRITE: begin
                rf_sb  = 1'b1;
                ram_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Bench for mul_job_sequencer with a behavioural ROM (ROM[i] = i), RF, multiplier and RAM around it.
module tb_mul_job_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_adr1 = '0;
    logic [2:0] cmd_adr2 = '0;
    logic [2:0] cmd_adr_ram = '0;
    logic [2:0] rom_addr;
    logic       rf_w, rf_da, rf_sa, rf_sb, ram_we;
    logic [2:0] ram_addr;
    logic [7:0] ram_rdata;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [2:0] rsp_addr;
    logic       busy;
    logic [7:0] jobs_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [10:0] exp_q [$];

    mul_job_sequencer #(.FIFO_DEPTH(4), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_adr1(cmd_adr1), .cmd_adr2(cmd_adr2), .cmd_adr_ram(cmd_adr_ram),
        .rom_addr(rom_addr), .rf_w(rf_w), .rf_da(rf_da), .rf_sa(rf_sa), .rf_sb(rf_sb),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath around the sequencer.
    logic [3:0] r0 = '0;
    logic [3:0] r1 = '0;
    logic [7:0] ram_mem [8];
    logic [3:0] rom_data, a_bus, b_bus;
    logic [7:0] product;
    assign rom_data = {1'b0, rom_addr};
    assign a_bus    = rf_sa ? r1 : r0;
    assign b_bus    = rf_sb ? r1 : r0;
    assign product  = {4'd0, a_bus} * {4'd0, b_bus};

    initial begin
        for (int i = 0; i < 8; i++) ram_mem[i] = 8'd0;
        ram_rdata = 8'd0;
    end

    always @(posedge clk) begin
        if (rf_w) begin
            if (rf_da) r1 <= rom_data;
            else       r0 <= rom_data;
        end
        if (ram_we) ram_mem[ram_addr] <= product;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [12:0] pk(input logic [2:0] ra, input logic w, input logic da,
                                       input logic sa, input logic sb, input logic we,
                                       input logic [2:0] ma, input logic v, input logic b);
        return {ra, w, da, sa, sb, we, ma, v, b};
    endfunction

    function automatic logic [12:0] ctl_now();
        return pk(rom_addr, rf_w, rf_da, rf_sa, rf_sb, ram_we, ram_addr, rsp_valid, busy);
    endfunction

    // Scoreboard monitor: every response handshake is compared against the oldest expectation.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got addr %0d data %0d expected none", rsp_addr, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_addr", 32'(rsp_addr), 32'(e[10:8]));
                    check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic send(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] ar, input logic [7:0] prod);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_adr1 = a1; cmd_adr2 = a2; cmd_adr_ram = ar;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back({ar, prod});
                ok = 1;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) fail_msg("send_timeout");
    endtask

    task automatic offer(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] ar,
                         input logic [7:0] prod, output bit acc);
        cmd_valid = 1'b1; cmd_adr1 = a1; cmd_adr2 = a2; cmd_adr_ram = ar;
        @(negedge clk);
        acc = cmd_ready;
        if (acc) exp_q.push_back({ar, prod});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
        if (!ok) fail_msg("wait_rsp_valid");
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) ok = 1;
        end
        if (!ok) fail_msg("drain_timeout");
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'(ctl_now()), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
        check({tag, "_jobs_done"}, 32'(jobs_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] seq [7];
        int ht [5];
        int nh;
        int acc_cnt;
        bit acc;
        bit ok;

        // Asynchronous reset asserted mid-cycle, before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single job: per-cycle control trace, cycles 1..7 after acceptance.
        seq[0] = pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        seq[1] = pk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1);
        seq[2] = pk(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1);
        seq[3] = pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
        seq[4] = pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1);
        seq[5] = pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1);
        seq[6] = pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
        send(3'd3, 3'd5, 3'd2, 8'd15);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("single_ctl_c%0d", c + 1), 32'(ctl_now()), 32'(seq[c]));
        end
        check("single_rsp_data", 32'(rsp_data), 32'd15);
        check("single_rsp_addr", 32'(rsp_addr), 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_jobs_done", 32'(jobs_done), 32'd1);
        check("single_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Edge operands.
        send(3'd7, 3'd7, 3'd7, 8'd49);
        send(3'd0, 3'd6, 3'd0, 8'd0);
        send(3'd4, 3'd4, 3'd4, 8'd16);
        drain();
        @(negedge clk);
        check("edge_jobs_done", 32'(jobs_done), 32'd4);
        @(posedge clk); #1;

        // Backpressure: 6 offers, 5 fit (1 in flight + 4 queued).
        rsp_ready = 1'b0;
        acc_cnt = 0;
        offer(3'd1, 3'd2, 3'd1, 8'd2, acc);  acc_cnt += int'(acc);
        offer(3'd2, 3'd3, 3'd3, 8'd6, acc);  acc_cnt += int'(acc);
        offer(3'd6, 3'd5, 3'd5, 8'd30, acc); acc_cnt += int'(acc);
        offer(3'd7, 3'd3, 3'd6, 8'd21, acc); acc_cnt += int'(acc);
        offer(3'd2, 3'd2, 3'd0, 8'd4, acc);  acc_cnt += int'(acc);
        offer(3'd5, 3'd5, 3'd4, 8'd25, acc); acc_cnt += int'(acc);
        check("bp_accept_count", 32'(acc_cnt), 32'd5);
        @(negedge clk);
        check("bp_cmd_ready_full", 32'(cmd_ready), 32'd0);
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_ctl", 32'(ctl_now()), 32'(pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1)));
            check("bp_hold_data", 32'(rsp_data), 32'd2);
            check("bp_hold_addr", 32'(rsp_addr), 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        nh = 0;
        for (int i = 0; i < 100 && nh < 5; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                ht[nh] = cyc;
                nh++;
            end
        end
        check("bp_response_count", 32'(nh), 32'd5);
        for (int k = 1; k < 5; k++) begin
            if (k < nh) check($sformatf("bp_gap_%0d", k), 32'(ht[k] - ht[k-1]), 32'd6);
        end
        drain();
        @(negedge clk);
        check("bp_jobs_done", 32'(jobs_done), 32'd9);
        @(posedge clk); #1;

        // Simultaneous push and pop with 2 jobs queued.
        rsp_ready = 1'b0;
        send(3'd1, 3'd1, 3'd1, 8'd1);
        send(3'd3, 3'd3, 3'd3, 8'd9);
        send(3'd5, 3'd6, 3'd2, 8'd30);
        wait_valid();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        offer(3'd2, 3'd7, 3'd6, 8'd14, acc);
        check("pp_push_accepted", 32'(acc), 32'd1);
        rsp_ready = 1'b0;
        acc_cnt = 0;
        offer(3'd3, 3'd4, 3'd4, 8'd12, acc); acc_cnt += int'(acc);
        offer(3'd1, 3'd7, 3'd7, 8'd7, acc);  acc_cnt += int'(acc);
        offer(3'd6, 3'd6, 3'd5, 8'd36, acc); acc_cnt += int'(acc);
        check("pp_room_after", 32'(acc_cnt), 32'd2);
        rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        check("pp_jobs_done", 32'(jobs_done), 32'd15);
        @(posedge clk); #1;

        // Reset while a job sits in WRITE with another queued.
        send(3'd2, 3'd5, 3'd3, 8'd10);
        send(3'd1, 3'd3, 3'd2, 8'd3);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ram_we) ok = 1;
        end
        if (!ok) fail_msg("wait_write_state");
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_write");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_write_quiet", 32'({rsp_valid, busy}), 32'd0);
        end
        @(posedge clk); #1;
        send(3'd6, 3'd7, 3'd1, 8'd42);
        drain();
        @(negedge clk);
        check("rst_write_jobs_done", 32'(jobs_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
